// File: rtl/led_disp_pkg.sv
// Shared types and constants for the multiplexed LED display path:
// segment type, scan FSM states and the HELLO glyph codes.
package led_disp_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam seg_t GLYPH_H = 8'h76;
  localparam seg_t GLYPH_E = 8'h79;
  localparam seg_t GLYPH_L = 8'h38;
  localparam seg_t GLYPH_O = 8'h3F;

endpackage

// File: rtl/led_scan_timer.sv
// Loadable down-counter with a zero flag; times both the blank and dwell slots.
// Holds at zero until reloaded.
module led_scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/led_scan_sched.sv
// Scan scheduler for a multiplexed LED display: double-buffered frame intake over
// valid/ready, blank/show slot sequencing per digit and a frame-start pulse.
module led_scan_sched
  import led_disp_pkg::*;
#(
  parameter int pNO_LED = 8,
  parameter int pDWELL  = 1000,
  parameter int pBLANK  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  seg_t [pNO_LED-1:0]       frame_data,
  output seg_t                     seg_o,
  output logic [pNO_LED-1:0]       dig_sel_o,
  output logic                     frame_done_o
);

  localparam int TMAX = (pDWELL > pBLANK) ? pDWELL : pBLANK;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(pNO_LED);

  localparam logic [TW-1:0] BLANK_LOAD = TW'(pBLANK - 1);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(pDWELL - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(pNO_LED - 1);

  state_t               state_reg, state_next;
  logic [IW-1:0]        idx_reg, idx_next;
  seg_t [pNO_LED-1:0]   pending_reg, active_reg, active_next;
  logic                 pending_full_reg;
  logic                 accept, promote;

  logic                 timer_load, timer_dec, timer_zero;
  logic [TW-1:0]        timer_val, timer_count;

  seg_t                 seg_reg, seg_next;
  logic [pNO_LED-1:0]   dig_sel_reg, dig_sel_next, idx_onehot;
  logic                 frame_done_reg, frame_done_next;

  led_scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  // Accept needs an empty pending buffer, so accept and promote never coincide.
  assign accept      = frame_valid && !pending_full_reg;
  assign frame_ready = !pending_full_reg;

  // Swap only at a frame boundary: while parked, or in the first blank slot of digit 0.
  assign promote = pending_full_reg &&
                   ((state_reg == IDLE) ||
                    ((state_reg == BLANK) && (idx_reg == '0) && (timer_count == BLANK_LOAD)));

  assign active_next = promote ? pending_reg : active_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg      <= '0;
      active_reg       <= '0;
      pending_full_reg <= 1'b0;
    end else begin
      active_reg <= active_next;
      if (accept) begin
        pending_reg      <= frame_data;
        pending_full_reg <= 1'b1;
      end else if (promote) begin
        pending_full_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    timer_dec  = 1'b0;
    if (!en) begin
      state_next = IDLE;
      idx_next   = '0;
      timer_load = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = BLANK;
          idx_next   = '0;
          timer_load = 1'b1;
          timer_val  = BLANK_LOAD;
        end
        BLANK: begin
          if (timer_zero) begin
            state_next = SHOW;
            timer_load = 1'b1;
            timer_val  = DWELL_LOAD;
          end else begin
            timer_dec = 1'b1;
          end
        end
        SHOW: begin
          if (timer_zero) begin
            state_next = BLANK;
            timer_load = 1'b1;
            timer_val  = BLANK_LOAD;
            idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
          end else begin
            timer_dec = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < pNO_LED; gi++) begin : g_onehot
    assign idx_onehot[gi] = (idx_next == IW'(gi));
  end

  // Segments and digit select are registered from the same next-state so they flip together.
  always_comb begin
    seg_next     = '0;
    dig_sel_next = '0;
    if (state_next == SHOW) begin
      seg_next     = active_next[idx_next];
      dig_sel_next = idx_onehot;
    end
    frame_done_next = en && (state_reg == SHOW) && timer_zero && (idx_reg == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      seg_reg        <= '0;
      dig_sel_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      seg_reg        <= seg_next;
      dig_sel_reg    <= dig_sel_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign seg_o        = seg_reg;
  assign dig_sel_o    = dig_sel_reg;
  assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_led_scan_sched.sv
// Bench for led_scan_sched with 4 digits, dwell 3, blank 1: table of per-cycle
// vectors checked through a scoreboard queue, plus enable-drop and reset sequences.
module tb_led_scan_sched;
  import led_disp_pkg::*;

  localparam int N = 4;
  localparam int D = 3;
  localparam int B = 1;
  localparam int NV = 37;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        frame_valid;
  logic        frame_ready;
  logic [31:0] frame_data;
  seg_t        seg_o;
  logic [3:0]  dig_sel_o;
  logic        frame_done_o;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  led_scan_sched #(.pNO_LED(N), .pDWELL(D), .pBLANK(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .seg_o        (seg_o),
    .dig_sel_o    (dig_sel_o),
    .frame_done_o (frame_done_o)
  );

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic [3:0]  dig;
    logic [7:0]  seg;
    logic        done;
    logic        rdy;
  } vec_t;

  typedef struct {
    int         k;
    logic [3:0] dig;
    logic [7:0] seg;
    logic       done;
    logic       rdy;
  } exp_t;

  vec_t vec [NV];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fa, fb, fc, fd, fr;
    logic [3:0]  one;
    exp_t        e;
    bit          found;
    int          shows;

    fa  = {GLYPH_O, GLYPH_L, GLYPH_E, GLYPH_H};
    fb  = {4{GLYPH_L}};
    fc  = 32'h065B4F66;
    fd  = 32'h11223344;
    one = 4'b0001;

    // Per-cycle expectations after each clock edge once scanning starts (cycle 0 = first blank).
    for (int k = 0; k < NV; k++) begin
      int pos, d, s;
      pos = k % 16;
      d   = pos / 4;
      s   = pos % 4;
      fr  = (k <= 16) ? fa : ((k <= 32) ? fb : fc);
      vec[k].vld  = (k >= 6) && (k <= 18);
      vec[k].data = (k == 6) ? fb : ((k >= 7 && k <= 18) ? fc : 32'h0);
      vec[k].dig  = (s == 0) ? 4'b0000 : (one << d);
      vec[k].seg  = (s == 0) ? 8'h00 : fr[8*d +: 8];
      vec[k].done = (k == 16) || (k == 32);
      vec[k].rdy  = !(((k >= 6) && (k <= 16)) || ((k >= 18) && (k <= 32)));
    end

    rst = 1'b1;
    en = 1'b0;
    frame_valid = 1'b0;
    frame_data = 32'h0;
    step();
    chk("rst_seg", seg_o, 8'h00);
    chk("rst_dig", dig_sel_o, 4'h0);
    chk("rst_done", frame_done_o, 1'b0);
    chk("rst_ready", frame_ready, 1'b1);
    rst = 1'b0;
    step();
    chk("idle_dig", dig_sel_o, 4'h0);

    // Load frame A while parked.
    frame_valid = 1'b1;
    frame_data  = fa;
    step();
    chk("loadA_ready_low", frame_ready, 1'b0);
    frame_valid = 1'b0;
    frame_data  = 32'h0;
    step();
    chk("loadA_promoted_ready", frame_ready, 1'b1);
    chk("idle_seg", seg_o, 8'h00);

    for (int k = 0; k < NV; k++) begin
      en          = 1'b1;
      frame_valid = vec[k].vld;
      frame_data  = vec[k].data;
      sb.push_back('{k: k, dig: vec[k].dig, seg: vec[k].seg, done: vec[k].done, rdy: vec[k].rdy});
      step();
      e = sb.pop_front();
      chk($sformatf("c%0d_dig", e.k), dig_sel_o, e.dig);
      chk($sformatf("c%0d_seg", e.k), seg_o, e.seg);
      chk($sformatf("c%0d_done", e.k), frame_done_o, e.done);
      chk($sformatf("c%0d_ready", e.k), frame_ready, e.rdy);
      $display("cycle %0d: dig=%b seg=%h done=%b ready=%b", e.k, dig_sel_o, seg_o, frame_done_o, frame_ready);
    end
    frame_valid = 1'b0;
    frame_data  = 32'h0;

    // Drop enable during digit 2.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (dig_sel_o == 4'b0100) found = 1'b1;
    end
    chk("reach_digit2", found, 1'b1);
    en = 1'b0;
    step();
    chk("en_off_dig", dig_sel_o, 4'h0);
    chk("en_off_seg", seg_o, 8'h00);
    chk("en_off_done", frame_done_o, 1'b0);
    step();
    chk("parked_dig", dig_sel_o, 4'h0);
    en = 1'b1;
    step();
    chk("restart_blank_dig", dig_sel_o, 4'h0);
    chk("restart_blank_done", frame_done_o, 1'b0);
    step();
    chk("restart_d0_dig", dig_sel_o, 4'b0001);
    chk("restart_d0_seg", seg_o, fc[7:0]);
    chk("restart_d0_done", frame_done_o, 1'b0);
    $display("restart: dig=%b seg=%h", dig_sel_o, seg_o);

    // Reset mid-show with the pending buffer full.
    frame_valid = 1'b1;
    frame_data  = fd;
    step();
    chk("pendD_ready_low", frame_ready, 1'b0);
    chk("pendD_still_show", dig_sel_o, 4'b0001);
    frame_valid = 1'b0;
    frame_data  = 32'h0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", seg_o, 8'h00);
    chk("async_rst_dig", dig_sel_o, 4'h0);
    chk("async_rst_ready", frame_ready, 1'b1);
    chk("async_rst_done", frame_done_o, 1'b0);
    step();
    rst = 1'b0;
    en  = 1'b1;
    shows = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (dig_sel_o != 4'h0) begin
        shows++;
        chk($sformatf("post_rst_seg%0d", i), seg_o, 8'h00);
      end
      chk($sformatf("post_rst_ready%0d", i), frame_ready, 1'b1);
    end
    chk("post_rst_show_cycles", shows, 12);
    $display("post-reset frame: %0d show cycles", shows);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
